// File: rtl/commit_trace_checker_if.sv
// Expected-record channel plus live commit strobes seen by the trace checker.
// The producer side (trace source / core) drives records and strobes.
// The checker side drives exp_ready back to the record producer.
interface commit_trace_checker_if;
  logic        exp_valid;
  logic        exp_ready;
  logic [1:0]  exp_kind;
  logic [15:0] exp_addr;
  logic [15:0] exp_value;

  logic        RegWrite;
  logic [2:0]  WriteRegister;
  logic [15:0] WriteData;
  logic        MemRead;
  logic        MemWrite;
  logic [15:0] MemAddress;
  logic [15:0] MemDataIn;
  logic [15:0] MemDataOut;
  logic        Halt;

  modport master (
    output exp_valid, exp_kind, exp_addr, exp_value,
    output RegWrite, WriteRegister, WriteData, MemRead, MemWrite,
    output MemAddress, MemDataIn, MemDataOut, Halt,
    input  exp_ready
  );

  modport slave (
    input  exp_valid, exp_kind, exp_addr, exp_value,
    input  RegWrite, WriteRegister, WriteData, MemRead, MemWrite,
    input  MemAddress, MemDataIn, MemDataOut, Halt,
    output exp_ready
  );
endinterface

// File: rtl/commit_trace_checker.sv
// Golden-trace checker: compares live commit strobes against queued expected records.
// Latency: compare is combinational; verdict, counters and FIFO pointers update at the next edge.
// Backpressure: exp_ready drops when the FIFO is full or once the checker leaves RUN.
module commit_trace_checker #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  commit_trace_checker_if.slave  bus,
  output logic                   done_o,
  output logic                   fail_o,
  output logic [2:0]             fail_code_o,
  output logic [CNT_W-1:0]       fail_cycle_o,
  output logic [CNT_W-1:0]       match_count_o,
  output logic [$clog2(DEPTH):0] fifo_level_o
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  localparam logic [2:0] FC_NONE   = 3'd0;
  localparam logic [2:0] FC_STARVE = 3'd1;
  localparam logic [2:0] FC_KIND   = 3'd2;
  localparam logic [2:0] FC_ADDR   = 3'd3;
  localparam logic [2:0] FC_DATA   = 3'd4;

  typedef enum logic [1:0] {ST_RUN, ST_DONE, ST_FAIL} state_e;

  typedef struct packed {
    logic [1:0]  kind;
    logic [15:0] addr;
    logic [15:0] value;
  } rec_t;

  rec_t             mem_q [DEPTH];
  state_e           state_q;
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             done_q, fail_q;
  logic [2:0]       code_q, code_d;
  logic [CNT_W-1:0] fcycle_q, cycle_q, match_q;

  logic             run, push, mis;
  logic [3:0]       ev;
  logic [LVL_W-1:0] n_ev, pop_n;
  logic [PTR_W-1:0] rd_idx;
  rec_t             ent;
  logic [15:0]      live_addr, live_value;

  assign run           = (state_q == ST_RUN);
  assign bus.exp_ready = run && (level_q < LVL_W'(DEPTH));
  assign push          = bus.exp_valid && bus.exp_ready;
  // Bit position equals the record kind, so scanning bits 0..3 walks trace order.
  assign ev            = {bus.Halt, bus.MemWrite, bus.MemRead, bus.RegWrite};

  // Walk this cycle's events in trace order against head+i; stop at the first divergence.
  always_comb begin
    n_ev       = '0;
    mis        = 1'b0;
    code_d     = FC_NONE;
    rd_idx     = '0;
    ent        = '0;
    live_addr  = '0;
    live_value = '0;
    for (int k = 0; k < 4; k++) begin
      if (ev[k] && !mis) begin
        rd_idx    = head_q + n_ev[PTR_W-1:0];
        ent       = mem_q[rd_idx];
        live_addr = (k == 0) ? {13'b0, bus.WriteRegister} : bus.MemAddress;
        if (k == 0)      live_value = bus.WriteData;
        else if (k == 1) live_value = bus.MemDataOut;
        else             live_value = bus.MemDataIn;
        if (level_q <= n_ev) begin
          mis    = 1'b1;
          code_d = FC_STARVE;
        end else if (ent.kind != 2'(k)) begin
          mis    = 1'b1;
          code_d = FC_KIND;
        end else if ((k != 3) && (ent.addr != live_addr)) begin
          mis    = 1'b1;
          code_d = FC_ADDR;
        end else if ((k != 3) && (ent.value != live_value)) begin
          mis    = 1'b1;
          code_d = FC_DATA;
        end else begin
          n_ev = n_ev + 1'b1;
        end
      end
    end
  end

  // Pop only on a clean cycle in RUN; a full FIFO refuses the push even if it pops.
  always_comb begin
    pop_n   = (run && !mis) ? n_ev : '0;
    head_d  = head_q + pop_n[PTR_W-1:0];
    tail_d  = tail_q + PTR_W'(push);
    level_d = level_q + LVL_W'(push) - pop_n;
  end

  // Record storage; contents need no reset since level gates every read.
  always_ff @(posedge clk) begin
    if (push) mem_q[tail_q] <= '{kind: bus.exp_kind, addr: bus.exp_addr, value: bus.exp_value};
  end

  // Checker FSM with FIFO pointers, counters and registered verdict outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_RUN;
      head_q   <= '0;
      tail_q   <= '0;
      level_q  <= '0;
      done_q   <= 1'b0;
      fail_q   <= 1'b0;
      code_q   <= FC_NONE;
      fcycle_q <= '0;
      cycle_q  <= '0;
      match_q  <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      level_q <= level_d;
      case (state_q)
        ST_RUN: begin
          cycle_q <= cycle_q + 1'b1;
          if (mis) begin
            state_q  <= ST_FAIL;
            fail_q   <= 1'b1;
            code_q   <= code_d;
            fcycle_q <= cycle_q;
          end else begin
            match_q <= match_q + CNT_W'(n_ev);
            if (ev[3]) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign done_o        = done_q;
  assign fail_o        = fail_q;
  assign fail_code_o   = code_q;
  assign fail_cycle_o  = fcycle_q;
  assign match_count_o = match_q;
  assign fifo_level_o  = level_q;
endmodule

// File: tb/tb_commit_trace_checker.sv
// Bench for commit_trace_checker: directed scenarios plus randomized trace episodes.
// A queue-based reference model tracks expected records, counters and verdict.
module tb_commit_trace_checker;
  localparam int DEPTH = 8;
  localparam int CNT_W = 32;

  typedef struct packed {
    logic [1:0]  kind;
    logic [15:0] addr;
    logic [15:0] value;
  } rec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  commit_trace_checker_if bus();

  logic             done, fail;
  logic [2:0]       fail_code;
  logic [CNT_W-1:0] fail_cycle, match_count;
  logic [3:0]       fifo_level;

  commit_trace_checker #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .done_o(done), .fail_o(fail), .fail_code_o(fail_code),
    .fail_cycle_o(fail_cycle), .match_count_o(match_count), .fifo_level_o(fifo_level)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: 0=running, 1=done, 2=failed
  rec_t        m_q[$];
  int          m_state;
  int          m_code;
  int unsigned m_cycle, m_match, m_fcycle;

  task automatic model_reset();
    m_q.delete();
    m_state = 0; m_code = 0; m_cycle = 0; m_match = 0; m_fcycle = 0;
  endtask

  // Apply the checking rules to the currently driven inputs for one clock.
  task automatic model_step();
    rec_t r;
    int code, n;
    bit push;
    logic [3:0] evs;
    logic [15:0] la, lv;
    push = bus.exp_valid && (m_state == 0) && (int'(m_q.size()) < DEPTH);
    if (m_state == 0) begin
      evs = {bus.Halt, bus.MemWrite, bus.MemRead, bus.RegWrite};
      code = 0; n = 0;
      for (int k = 0; k < 4; k++) begin
        if (evs[k] && code == 0) begin
          if (n >= int'(m_q.size())) code = 1;
          else begin
            r  = m_q[n];
            la = (k == 0) ? {13'b0, bus.WriteRegister} : bus.MemAddress;
            lv = (k == 0) ? bus.WriteData : (k == 1) ? bus.MemDataOut : bus.MemDataIn;
            if (int'(r.kind) != k) code = 2;
            else if (k != 3 && r.addr != la) code = 3;
            else if (k != 3 && r.value != lv) code = 4;
          end
          if (code == 0) n++;
        end
      end
      if (code != 0) begin
        m_state = 2; m_code = code; m_fcycle = m_cycle;
      end else begin
        for (int i = 0; i < n; i++) void'(m_q.pop_front());
        m_match += n;
        if (bus.Halt) m_state = 1;
      end
      m_cycle++;
    end
    if (push) m_q.push_back({bus.exp_kind, bus.exp_addr, bus.exp_value});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_cycle();
    model_step();
    tick();
  endtask

  task automatic clear_live();
    bus.RegWrite = 0; bus.WriteRegister = 0; bus.WriteData = 0;
    bus.MemRead = 0; bus.MemWrite = 0; bus.MemAddress = 0;
    bus.MemDataIn = 0; bus.MemDataOut = 0; bus.Halt = 0;
  endtask

  task automatic clear_inputs();
    clear_live();
    bus.exp_valid = 0; bus.exp_kind = 0; bus.exp_addr = 0; bus.exp_value = 0;
  endtask

  task automatic offer(input logic [1:0] kind, input logic [15:0] addr, input logic [15:0] value);
    bus.exp_valid = 1; bus.exp_kind = kind; bus.exp_addr = addr; bus.exp_value = value;
  endtask

  task automatic apply_reset();
    rst = 1;
    clear_inputs();
    tick();
    rst = 0;
    model_reset();
  endtask

  // Drive strobes that match a legal prefix of the model queue, occasionally corrupted.
  task automatic drive_live_random();
    rec_t r;
    int want, taken, last;
    bit ld;
    logic [15:0] la;
    clear_live();
    want = $urandom_range(0, 3); taken = 0; last = -1; ld = 0; la = 0;
    for (int i = 0; i < int'(m_q.size()) && taken < want; i++) begin
      r = m_q[i];
      if (int'(r.kind) <= last) break;
      if (r.kind == 2'd0 && r.addr[15:3] != 13'd0) break;
      if (r.kind == 2'd2 && ld && r.addr != la) break;
      case (r.kind)
        2'd0: begin bus.RegWrite = 1; bus.WriteRegister = r.addr[2:0]; bus.WriteData = r.value; end
        2'd1: begin bus.MemRead = 1; bus.MemAddress = r.addr; bus.MemDataOut = r.value; ld = 1; la = r.addr; end
        2'd2: begin bus.MemWrite = 1; bus.MemAddress = r.addr; bus.MemDataIn = r.value; end
        default: bus.Halt = 1;
      endcase
      last = int'(r.kind); taken++;
    end
    if ($urandom_range(0, 9) == 0) begin
      case ($urandom_range(0, 3))
        0: begin bus.RegWrite = 1; bus.WriteData = bus.WriteData ^ 16'h0001; end
        1: begin bus.MemRead = 1; bus.MemAddress = bus.MemAddress ^ 16'h0100; end
        2: begin bus.MemWrite = 1; bus.MemDataIn = bus.MemDataIn ^ 16'h8000; end
        default: bus.Halt = 1;
      endcase
    end
  endtask

  task automatic offer_random();
    logic [1:0] k;
    k = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
    bus.exp_valid = ($urandom_range(0, 2) != 0);
    bus.exp_kind  = k;
    bus.exp_addr  = (k == 2'd0) ? 16'($urandom_range(0, 7)) : 16'($urandom_range(0, 3) * 16);
    bus.exp_value = 16'($urandom);
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%0b exp=0", done); end
    checks++; if (fail !== 1'b0) begin errors++; $display("FAIL reset_fail got=%0b exp=0", fail); end
    checks++; if (fail_code !== 3'd0) begin errors++; $display("FAIL reset_code got=%0d exp=0", fail_code); end
    checks++; if (fail_cycle !== '0) begin errors++; $display("FAIL reset_fcycle got=%0d exp=0", fail_cycle); end
    checks++; if (match_count !== '0) begin errors++; $display("FAIL reset_match got=%0d exp=0", match_count); end
    checks++; if (fifo_level !== 4'd0) begin errors++; $display("FAIL reset_level got=%0d exp=0", fifo_level); end
    checks++; if (bus.exp_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%0b exp=1", bus.exp_ready); end
  endtask

  task automatic test_single_reg();
    apply_reset();
    offer(2'd0, 16'd3, 16'h0042);
    run_cycle();
    clear_inputs();
    bus.RegWrite = 1; bus.WriteRegister = 3'd3; bus.WriteData = 16'h0042;
    run_cycle();
    clear_inputs();
    checks++; if (match_count !== 32'd1) begin errors++; $display("FAIL t1_match got=%0d exp=1", match_count); end
    checks++; if (fifo_level !== 4'd0) begin errors++; $display("FAIL t1_level got=%0d exp=0", fifo_level); end
    checks++; if (fail !== 1'b0) begin errors++; $display("FAIL t1_fail got=%0b exp=0", fail); end
  endtask

  task automatic test_two_events();
    apply_reset();
    offer(2'd0, 16'd1, 16'h1111);
    run_cycle();
    offer(2'd1, 16'h0010, 16'hBEEF);
    run_cycle();
    clear_inputs();
    bus.RegWrite = 1; bus.WriteRegister = 3'd1; bus.WriteData = 16'h1111;
    bus.MemRead = 1; bus.MemAddress = 16'h0010; bus.MemDataOut = 16'hBEEF;
    run_cycle();
    clear_inputs();
    checks++; if (match_count !== 32'd2) begin errors++; $display("FAIL t2_match got=%0d exp=2", match_count); end
    checks++; if (fifo_level !== 4'd0) begin errors++; $display("FAIL t2_level got=%0d exp=0", fifo_level); end
    checks++; if (fail !== 1'b0) begin errors++; $display("FAIL t2_fail got=%0b exp=0", fail); end
  endtask

  task automatic test_data_fail();
    apply_reset();
    offer(2'd2, 16'h0020, 16'h00AA);
    run_cycle();
    clear_inputs();
    repeat (4) run_cycle();
    bus.MemWrite = 1; bus.MemAddress = 16'h0020; bus.MemDataIn = 16'h00AB;
    run_cycle();
    checks++; if (fail !== 1'b1) begin errors++; $display("FAIL t3_fail got=%0b exp=1", fail); end
    checks++; if (fail_code !== 3'd4) begin errors++; $display("FAIL t3_code got=%0d exp=4", fail_code); end
    checks++; if (fail_cycle !== 32'd5) begin errors++; $display("FAIL t3_fcycle got=%0d exp=5", fail_cycle); end
    checks++; if (fifo_level !== 4'd1) begin errors++; $display("FAIL t3_level got=%0d exp=1", fifo_level); end
    // Live strobes must be ignored once failed.
    bus.MemDataIn = 16'h00AA;
    run_cycle();
    clear_inputs();
    checks++; if (match_count !== 32'd0) begin errors++; $display("FAIL t3_hold_match got=%0d exp=0", match_count); end
    checks++; if (fail_cycle !== 32'd5) begin errors++; $display("FAIL t3_hold_fcycle got=%0d exp=5", fail_cycle); end
  endtask

  task automatic test_starve();
    apply_reset();
    bus.RegWrite = 1;
    run_cycle();
    clear_inputs();
    checks++; if (fail_code !== 3'd1) begin errors++; $display("FAIL t4_code got=%0d exp=1", fail_code); end
    checks++; if (fail !== 1'b1) begin errors++; $display("FAIL t4_fail got=%0b exp=1", fail); end
    offer(2'd0, 16'd0, 16'd0);
    #1;
    checks++; if (bus.exp_ready !== 1'b0) begin errors++; $display("FAIL t4_ready got=%0b exp=0", bus.exp_ready); end
    run_cycle();
    clear_inputs();
    checks++; if (fifo_level !== 4'd0) begin errors++; $display("FAIL t4_level got=%0d exp=0", fifo_level); end
  endtask

  task automatic test_back_to_back();
    int unsigned start;
    int cyc;
    apply_reset();
    for (int i = 0; i < DEPTH; i++) begin
      offer(2'd0, 16'(i % 8), 16'($urandom));
      run_cycle();
    end
    clear_inputs();
    checks++; if (fifo_level !== 4'd8) begin errors++; $display("FAIL t5_full_level got=%0d exp=8", fifo_level); end
    checks++; if (bus.exp_ready !== 1'b0) begin errors++; $display("FAIL t5_full_ready got=%0b exp=0", bus.exp_ready); end
    offer(2'd0, 16'd0, 16'h5555);
    bus.RegWrite = 1; bus.WriteRegister = m_q[0].addr[2:0]; bus.WriteData = m_q[0].value;
    run_cycle();
    clear_inputs();
    checks++; if (fifo_level !== 4'd7) begin errors++; $display("FAIL t5_fullpop_level got=%0d exp=7", fifo_level); end
    checks++; if (match_count !== 32'd1) begin errors++; $display("FAIL t5_fullpop_match got=%0d exp=1", match_count); end
    start = m_match; cyc = 0;
    while (m_match < start + 20 && cyc < 300) begin
      clear_inputs();
      bus.exp_valid = ($urandom_range(0, 1) == 1);
      bus.exp_kind = 2'd0; bus.exp_addr = 16'($urandom_range(0, 7)); bus.exp_value = 16'($urandom);
      if (m_q.size() > 0 && $urandom_range(0, 4) != 0) begin
        bus.RegWrite = 1; bus.WriteRegister = m_q[0].addr[2:0]; bus.WriteData = m_q[0].value;
      end
      run_cycle();
      cyc++;
      checks++; if (fifo_level !== 4'(m_q.size())) begin errors++; $display("FAIL t5_wrap_level got=%0d exp=%0d", fifo_level, m_q.size()); end
      checks++; if (match_count !== m_match) begin errors++; $display("FAIL t5_wrap_match got=%0d exp=%0d", match_count, m_match); end
    end
    clear_inputs();
    checks++; if (match_count < start + 20) begin errors++; $display("FAIL t5_wrap_budget got=%0d exp>=%0d", match_count, start + 20); end
    checks++; if (fail !== 1'b0) begin errors++; $display("FAIL t5_wrap_fail got=%0b exp=0", fail); end
  endtask

  task automatic test_halt_and_reset();
    apply_reset();
    offer(2'd3, 16'd0, 16'd0);
    run_cycle();
    offer(2'd0, 16'd2, 16'h2222);
    run_cycle();
    clear_inputs();
    bus.Halt = 1;
    run_cycle();
    clear_inputs();
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL t6_done got=%0b exp=1", done); end
    checks++; if (bus.exp_ready !== 1'b0) begin errors++; $display("FAIL t6_ready got=%0b exp=0", bus.exp_ready); end
    checks++; if (fifo_level !== 4'd1) begin errors++; $display("FAIL t6_leftover got=%0d exp=1", fifo_level); end
    checks++; if (match_count !== 32'd1) begin errors++; $display("FAIL t6_match got=%0d exp=1", match_count); end
    // Mid-run reset with activity on every input.
    apply_reset();
    offer(2'd0, 16'd5, 16'h0505);
    run_cycle();
    run_cycle();
    bus.RegWrite = 1; bus.WriteRegister = 3'd5; bus.WriteData = 16'h0505;
    run_cycle();
    rst = 1;
    bus.MemWrite = 1;
    tick();
    rst = 0;
    clear_inputs();
    model_reset();
    checks++; if (match_count !== '0) begin errors++; $display("FAIL t6_rst_match got=%0d exp=0", match_count); end
    checks++; if (fifo_level !== 4'd0) begin errors++; $display("FAIL t6_rst_level got=%0d exp=0", fifo_level); end
    checks++; if (fail !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL t6_rst_flags got=%0b%0b exp=00", fail, done); end
    checks++; if (bus.exp_ready !== 1'b1) begin errors++; $display("FAIL t6_rst_ready got=%0b exp=1", bus.exp_ready); end
  endtask

  task automatic test_random();
    for (int ep = 0; ep < 16; ep++) begin
      apply_reset();
      for (int c = 0; c < 60; c++) begin
        offer_random();
        drive_live_random();
        #1;
        checks++;
        if (bus.exp_ready !== ((m_state == 0) && (int'(m_q.size()) < DEPTH))) begin
          errors++; $display("FAIL rnd_ready ep=%0d c=%0d got=%0b", ep, c, bus.exp_ready);
        end
        run_cycle();
        checks++; if (done !== (m_state == 1)) begin errors++; $display("FAIL rnd_done ep=%0d c=%0d got=%0b exp=%0b", ep, c, done, m_state == 1); end
        checks++; if (fail !== (m_state == 2)) begin errors++; $display("FAIL rnd_fail ep=%0d c=%0d got=%0b exp=%0b", ep, c, fail, m_state == 2); end
        checks++; if (fail_code !== 3'(m_code)) begin errors++; $display("FAIL rnd_code ep=%0d c=%0d got=%0d exp=%0d", ep, c, fail_code, m_code); end
        checks++; if (fail_cycle !== m_fcycle) begin errors++; $display("FAIL rnd_fcycle ep=%0d c=%0d got=%0d exp=%0d", ep, c, fail_cycle, m_fcycle); end
        checks++; if (match_count !== m_match) begin errors++; $display("FAIL rnd_match ep=%0d c=%0d got=%0d exp=%0d", ep, c, match_count, m_match); end
        checks++; if (fifo_level !== 4'(m_q.size())) begin errors++; $display("FAIL rnd_level ep=%0d c=%0d got=%0d exp=%0d", ep, c, fifo_level, m_q.size()); end
      end
    end
    clear_inputs();
  endtask

  initial begin
    rst = 1;
    clear_inputs();
    model_reset();
    test_reset();
    test_single_reg();
    test_two_events();
    test_data_fail();
    test_starve();
    test_back_to_back();
    test_halt_and_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
